mac_rx_frame_buf: RTL and testbench
===================================

// Module: mac_rx_frame_buf
// PURPOSE
//   Store-and-forward RX frame controller behind the MAC RX AXIS output (no tready on its input).
//   Writes beats speculatively into a circular RAM and publishes a frame to the downstream AXIS
//   master only once its tlast beat arrives with tuser=0.
//   Errored frames (tuser=1 on last beat) and frames that overflow the buffer are rolled back.
//   The buffer never emits them, so downstream sees only complete, CRC-good frames.
// PARAMETERS
//   DEPTH   512                 RAM entries (beats); power of two, >=16
//   W_ADDR  $clog2(DEPTH)       pointer index width (derived, do not override)
//   W_CNT   16                  width of saturating drop counters
//   N_SYMBOLS/W_SYMBOL          from mac_params (beat = N_SYMBOLS*W_SYMBOL bits)
// PORTS
//   i_clk           in   1                    clock
//   i_reset         in   1                    synchronous active-high reset
//   i_clk_en        in   1                    input beat qualifier (PCS clock enable)
//   s_axis_tvalid   in   1                    beat from MAC RX
//   s_axis_tkeep    in   N_SYMBOLS            byte enables
//   s_axis_tdata    in   N_SYMBOLS*W_SYMBOL   beat data
//   s_axis_tlast    in   1                    last beat of frame
//   s_axis_tuser    in   1                    frame error (valid with tlast)
//   m_axis_tvalid   out  1                    output beat valid
//   m_axis_tready   in   1                    downstream ready
//   m_axis_tkeep    out  N_SYMBOLS            byte enables
//   m_axis_tdata    out  N_SYMBOLS*W_SYMBOL   beat data
//   m_axis_tlast    out  1                    last beat of frame
//   o_level         out  W_ADDR+1             occupied entries (wr_ptr - rd_ptr)
//   o_err_drop_cnt  out  W_CNT                frames dropped for tuser=1
//   o_ovf_drop_cnt  out  W_CNT                frames dropped for overflow
// BEHAVIOUR
//   - Input beat accepted iff s_axis_tvalid & i_clk_en. RAM entry = {tlast, tkeep, tdata}.
//   - Pointers are W_ADDR+1 bits: wr_ptr (speculative), commit_ptr, rd_ptr.
//     full = (wr_ptr - rd_ptr == DEPTH). Wrap is natural modulo 2^(W_ADDR+1).
//   - FSM: ST_IDLE, ST_FRAME, ST_DROP (one-hot).
//     IDLE:  beat -> write; tlast&!tuser -> commit, stay IDLE; tlast&tuser -> rollback, err_cnt++;
//            !tlast -> FRAME.
//     FRAME: beat & !full -> write; on tlast apply IDLE rules, then -> IDLE.
//     any beat arriving while full (IDLE or FRAME): not written. !tlast -> DROP;
//            tlast -> rollback, ovf_cnt++, -> IDLE.
//     DROP:  discard beats; on tlast -> rollback, ovf_cnt++, -> IDLE (tuser ignored).
//   - commit: commit_ptr <= wr_ptr + 1 (tlast beat included). rollback: wr_ptr <= commit_ptr.
//   - Frames longer than DEPTH beats always drop as overflow.
//   - Read side: RAM read is 1-cycle synchronous; single output register with a 1-entry
//     prefetch so m_axis sustains 1 beat/clk under tready=1.
//     Reads only when rd_ptr != commit_ptr.
//   - Latency: tlast accepted in cycle t with output stage empty -> first beat valid at t+2.
//   - AXIS rules: m_axis_* stable while tvalid & !tready; tvalid never drops without a handshake.
//   - Simultaneous read/write/commit/rollback in one cycle are all legal.
//     Rollback never moves wr_ptr below rd_ptr (commit_ptr >= rd_ptr always).
//   - Drop counters saturate at 2^W_CNT-1; each increments by at most 1 per cycle.
//   - Reset: all pointers 0, state IDLE; m_axis_tvalid/tlast/tkeep/tdata = 0, o_level = 0,
//     counters = 0. A frame partially received at reset is discarded without counting.
//     Any beats of that frame arriving after reset are written as a new frame.
// TESTING
//   1. 16-beat good frame, tready=1 -> 16 identical beats out, tlast on 16th,
//      first valid 2 clks after input tlast.
//   2. 8-beat frame, tuser=1 on last -> no m_axis_tvalid; o_err_drop_cnt=1; o_level back to 0.
//   3. DEPTH=16, tready=0, 20-beat frame then 8-beat good frame -> o_ovf_drop_cnt=1;
//      with tready=1 only the 8-beat frame emerges.
//   4. Two back-to-back 5-beat frames, tready pattern 1,0,1,0... -> 10 beats in order,
//      no loss/duplication, data held during stalls.
//   5. Assert i_reset after 5 beats of a frame -> outputs/o_level/counters 0 next clk;
//      subsequent 4-beat good frame passes intact.
//   6. W_CNT=2, five errored frames -> o_err_drop_cnt sticks at 3;
//      i_clk_en=0 with s_axis_tvalid=1 -> nothing written.

Source files
------------

// File: rtl/mac_rx_frame_buf.sv
// Store-and-forward RX frame buffer: beats are written speculatively into a circular RAM and a
// frame becomes readable only once its tlast arrives clean; errored/overflowing frames are rolled back.
module mac_rx_frame_buf #(
    parameter  int DEPTH     = 512,
    parameter  int W_CNT     = 16,
    parameter  int N_SYMBOLS = 8,
    parameter  int W_SYMBOL  = 8,
    localparam int W_ADDR    = $clog2(DEPTH)
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_clk_en,
    input  logic                            s_axis_tvalid,
    input  logic [N_SYMBOLS-1:0]            s_axis_tkeep,
    input  logic [N_SYMBOLS*W_SYMBOL-1:0]   s_axis_tdata,
    input  logic                            s_axis_tlast,
    input  logic                            s_axis_tuser,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [N_SYMBOLS-1:0]            m_axis_tkeep,
    output logic [N_SYMBOLS*W_SYMBOL-1:0]   m_axis_tdata,
    output logic                            m_axis_tlast,
    output logic [W_ADDR:0]                 o_level,
    output logic [W_CNT-1:0]                o_err_drop_cnt,
    output logic [W_CNT-1:0]                o_ovf_drop_cnt
);

    localparam int              W_DATA    = N_SYMBOLS * W_SYMBOL;
    localparam int              W_ENTRY   = 1 + N_SYMBOLS + W_DATA;
    localparam logic [W_ADDR:0] PTR_ONE   = (W_ADDR + 1)'(1);
    localparam logic [W_ADDR:0] PTR_DEPTH = (W_ADDR + 1)'(DEPTH);
    localparam logic [W_CNT-1:0] CNT_ONE  = W_CNT'(1);
    localparam logic [W_CNT-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_FRAME = 3'b010,
        ST_DROP  = 3'b100
    } state_e;

    state_e               state_q, state_d;
    logic [W_ADDR:0]      wr_ptr_q, wr_ptr_d;
    logic [W_ADDR:0]      commit_ptr_q, commit_ptr_d;
    logic [W_ADDR:0]      rd_ptr_q, rd_ptr_d;
    logic [W_CNT-1:0]     err_cnt_q, err_cnt_d;
    logic [W_CNT-1:0]     ovf_cnt_q, ovf_cnt_d;
    logic                 beat, full, wr_en, err_inc, ovf_inc;

    logic [W_ENTRY-1:0]   mem [DEPTH];
    logic [W_ENTRY-1:0]   ram_dat_q;
    logic                 ram_vld_q, ram_vld_d;
    logic [W_ENTRY-1:0]   out_dat_q, out_dat_d;
    logic                 out_vld_q, out_vld_d;
    logic [W_ENTRY-1:0]   skid_dat_q, skid_dat_d;
    logic                 skid_vld_q, skid_vld_d;
    logic                 pop, rd_en;
    logic [1:0]           occ_after;

    always_comb begin
        beat         = s_axis_tvalid & i_clk_en;
        full         = (wr_ptr_q - rd_ptr_q) == PTR_DEPTH;
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        wr_en        = 1'b0;
        err_inc      = 1'b0;
        ovf_inc      = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_FRAME: begin
                if (beat) begin
                    if (full) begin
                        if (s_axis_tlast) begin
                            wr_ptr_d = commit_ptr_q;
                            ovf_inc  = 1'b1;
                            state_d  = ST_IDLE;
                        end else begin
                            state_d  = ST_DROP;
                        end
                    end else begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                        if (s_axis_tlast) begin
                            state_d = ST_IDLE;
                            if (s_axis_tuser) begin
                                wr_ptr_d = commit_ptr_q;
                                err_inc  = 1'b1;
                            end else begin
                                commit_ptr_d = wr_ptr_q + PTR_ONE;
                            end
                        end else begin
                            state_d = ST_FRAME;
                        end
                    end
                end
            end
            ST_DROP: begin
                // Once a frame has overflowed, tuser no longer matters: it is counted as overflow.
                if (beat && s_axis_tlast) begin
                    wr_ptr_d = commit_ptr_q;
                    ovf_inc  = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        err_cnt_d = (err_inc && err_cnt_q != CNT_MAX) ? err_cnt_q + CNT_ONE : err_cnt_q;
        ovf_cnt_d = (ovf_inc && ovf_cnt_q != CNT_MAX) ? ovf_cnt_q + CNT_ONE : ovf_cnt_q;
    end

    // Read side: a RAM read is issued only if the output register plus the one-entry
    // prefetch can still absorb it, counting the read already in flight.
    always_comb begin
        pop        = out_vld_q & m_axis_tready;
        occ_after  = {1'b0, out_vld_q} + {1'b0, skid_vld_q} + {1'b0, ram_vld_q} - {1'b0, pop};
        rd_en      = (rd_ptr_q != commit_ptr_q) && !occ_after[1];
        rd_ptr_d   = rd_en ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        ram_vld_d  = rd_en;
        out_vld_d  = out_vld_q;
        out_dat_d  = out_dat_q;
        skid_vld_d = skid_vld_q;
        skid_dat_d = skid_dat_q;
        if (!out_vld_q || pop) begin
            if (skid_vld_q) begin
                out_vld_d  = 1'b1;
                out_dat_d  = skid_dat_q;
                skid_vld_d = ram_vld_q;
                skid_dat_d = ram_dat_q;
            end else if (ram_vld_q) begin
                out_vld_d  = 1'b1;
                out_dat_d  = ram_dat_q;
            end else begin
                out_vld_d  = 1'b0;
            end
        end else if (ram_vld_q) begin
            skid_vld_d = 1'b1;
            skid_dat_d = ram_dat_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            err_cnt_q    <= '0;
            ovf_cnt_q    <= '0;
            ram_vld_q    <= 1'b0;
            out_vld_q    <= 1'b0;
            out_dat_q    <= '0;
            skid_vld_q   <= 1'b0;
            skid_dat_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            err_cnt_q    <= err_cnt_d;
            ovf_cnt_q    <= ovf_cnt_d;
            ram_vld_q    <= ram_vld_d;
            out_vld_q    <= out_vld_d;
            out_dat_q    <= out_dat_d;
            skid_vld_q   <= skid_vld_d;
            skid_dat_q   <= skid_dat_d;
        end
    end

    // Read and write never alias: reads stay below commit_ptr, writes sit at or above it.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[W_ADDR-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        end
        ram_dat_q <= mem[rd_ptr_q[W_ADDR-1:0]];
    end

    assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = out_dat_q;
    assign m_axis_tvalid  = out_vld_q;
    assign o_level        = wr_ptr_q - rd_ptr_q;
    assign o_err_drop_cnt = err_cnt_q;
    assign o_ovf_drop_cnt = ovf_cnt_q;

endmodule

// File: tb/tb_mac_rx_frame_buf.sv
// Bench for mac_rx_frame_buf with a small buffer and narrow drop counters.
module tb_mac_rx_frame_buf;

    localparam int DEPTH = 16;
    localparam int W_CNT = 2;
    localparam int NS    = 8;
    localparam int WS    = 8;
    localparam int WD    = NS * WS;
    localparam int WA    = $clog2(DEPTH);

    typedef logic [WD+NS:0] beat_t;

    logic              clk = 1'b0;
    logic              i_reset, i_clk_en;
    logic              s_tvalid, s_tlast, s_tuser;
    logic [NS-1:0]     s_tkeep;
    logic [WD-1:0]     s_tdata;
    logic              m_tvalid, m_tready, m_tlast;
    logic [NS-1:0]     m_tkeep;
    logic [WD-1:0]     m_tdata;
    logic [WA:0]       o_level;
    logic [W_CNT-1:0]  o_err_drop_cnt, o_ovf_drop_cnt;

    beat_t exp_q[$];
    beat_t got_q[$];
    int    errors = 0;
    int    checks = 0;
    bit    vld_seen;

    always #5 clk = ~clk;

    mac_rx_frame_buf #(
        .DEPTH(DEPTH), .W_CNT(W_CNT), .N_SYMBOLS(NS), .W_SYMBOL(WS)
    ) dut (
        .i_clk(clk), .i_reset(i_reset), .i_clk_en(i_clk_en),
        .s_axis_tvalid(s_tvalid), .s_axis_tkeep(s_tkeep), .s_axis_tdata(s_tdata),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tkeep(m_tkeep),
        .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast),
        .o_level(o_level), .o_err_drop_cnt(o_err_drop_cnt), .o_ovf_drop_cnt(o_ovf_drop_cnt)
    );

    // Output monitor: records every beat that will handshake on the coming edge.
    always @(negedge clk) begin
        if (!i_reset) begin
            if (m_tvalid) vld_seen = 1'b1;
            if (m_tvalid && m_tready) got_q.push_back({m_tlast, m_tkeep, m_tdata});
        end
    end

    task automatic idle(input int n);
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0; i_clk_en = 1'b1;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drive_beat(input logic [WD-1:0] d, input logic [NS-1:0] k,
                              input logic l, input logic u, input logic en);
        s_tvalid = 1'b1; i_clk_en = en; s_tdata = d; s_tkeep = k; s_tlast = l; s_tuser = u;
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input int n, input logic err, input logic good_exp, input logic en);
        for (int i = 0; i < n; i++) begin
            logic [WD-1:0] d;
            logic [NS-1:0] k;
            logic          l;
            d = {$urandom, $urandom};
            l = (i == n - 1);
            k = l ? 8'($urandom_range(1, 255)) : '1;
            if (good_exp) exp_q.push_back({l, k, d});
            drive_beat(d, k, l, err & l, en);
        end
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0; i_clk_en = 1'b1;
    endtask

    task automatic wait_out(input int n);
        for (int c = 0; c < 300 && got_q.size() < n; c++) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        i_reset = 1'b1; m_tready = 1'b0;
        idle(3);
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b expected 0", m_tvalid); end
        checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast: got %b expected 0", m_tlast); end
        checks++; if (m_tkeep !== '0) begin errors++; $display("FAIL rst_tkeep: got %h expected 0", m_tkeep); end
        checks++; if (m_tdata !== '0) begin errors++; $display("FAIL rst_tdata: got %h expected 0", m_tdata); end
        checks++; if (o_level !== '0) begin errors++; $display("FAIL rst_level: got %0d expected 0", o_level); end
        checks++; if (o_err_drop_cnt !== '0) begin errors++; $display("FAIL rst_err_cnt: got %0d expected 0", o_err_drop_cnt); end
        checks++; if (o_ovf_drop_cnt !== '0) begin errors++; $display("FAIL rst_ovf_cnt: got %0d expected 0", o_ovf_drop_cnt); end
        i_reset = 1'b0;
        idle(1);
    endtask

    task automatic test_good_frame();
        int k;
        exp_q.delete(); got_q.delete();
        m_tready = 1'b1;
        send_frame(16, 1'b0, 1'b1, 1'b1);
        k = 0;
        while (k < 10) begin
            @(negedge clk);
            if (m_tvalid) break;
            k++;
        end
        checks++; if (k !== 2) begin errors++; $display("FAIL t1_latency: got %0d clks expected 2", k); end
        wait_out(16);
        checks++; if (got_q.size() !== 16) begin errors++; $display("FAIL t1_count: got %0d beats expected 16", got_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            beat_t e, g;
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL t1_beat: got %h expected %h", g, e); end
        end
        checks++; if (o_level !== '0) begin errors++; $display("FAIL t1_level: got %0d expected 0", o_level); end
    endtask

    task automatic test_err_frame();
        exp_q.delete(); got_q.delete();
        vld_seen = 1'b0;
        send_frame(8, 1'b1, 1'b0, 1'b1);
        idle(6);
        checks++; if (vld_seen !== 1'b0) begin errors++; $display("FAIL t2_no_output: got tvalid seen=%b expected 0", vld_seen); end
        checks++; if (o_err_drop_cnt !== 2'd1) begin errors++; $display("FAIL t2_err_cnt: got %0d expected 1", o_err_drop_cnt); end
        checks++; if (o_ovf_drop_cnt !== 2'd0) begin errors++; $display("FAIL t2_ovf_cnt: got %0d expected 0", o_ovf_drop_cnt); end
        checks++; if (o_level !== '0) begin errors++; $display("FAIL t2_level: got %0d expected 0", o_level); end
    endtask

    task automatic test_overflow();
        exp_q.delete(); got_q.delete();
        m_tready = 1'b0;
        send_frame(20, 1'b0, 1'b0, 1'b1);
        idle(3);
        checks++; if (o_level !== '0) begin errors++; $display("FAIL t3_rollback_level: got %0d expected 0", o_level); end
        checks++; if (o_ovf_drop_cnt !== 2'd1) begin errors++; $display("FAIL t3_ovf_cnt: got %0d expected 1", o_ovf_drop_cnt); end
        send_frame(8, 1'b0, 1'b1, 1'b1);
        idle(6);
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL t3_stalled: got %0d beats expected 0", got_q.size()); end
        checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL t3_pending_valid: got %b expected 1", m_tvalid); end
        m_tready = 1'b1;
        wait_out(8);
        checks++; if (got_q.size() !== 8) begin errors++; $display("FAIL t3_count: got %0d beats expected 8", got_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            beat_t e, g;
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL t3_beat: got %h expected %h", g, e); end
        end
        checks++; if (o_ovf_drop_cnt !== 2'd1) begin errors++; $display("FAIL t3_ovf_final: got %0d expected 1", o_ovf_drop_cnt); end
    endtask

    task automatic test_back_to_back();
        exp_q.delete(); got_q.delete();
        m_tready = 1'b1;
        fork
            begin
                send_frame(5, 1'b0, 1'b1, 1'b1);
                send_frame(5, 1'b0, 1'b1, 1'b1);
            end
            begin
                logic  pv, pr;
                beat_t pd;
                pv = 1'b0; pr = 1'b1; pd = '0;
                for (int c = 0; c < 40; c++) begin
                    @(negedge clk);
                    if (pv && !pr) begin
                        checks++;
                        if (m_tvalid !== 1'b1 || {m_tlast, m_tkeep, m_tdata} !== pd) begin
                            errors++;
                            $display("FAIL t4_stall_hold: got vld=%b %h expected vld=1 %h",
                                     m_tvalid, {m_tlast, m_tkeep, m_tdata}, pd);
                        end
                    end
                    pv = m_tvalid; pr = m_tready; pd = {m_tlast, m_tkeep, m_tdata};
                    @(posedge clk); #1;
                    m_tready = ~m_tready;
                end
            end
        join
        m_tready = 1'b1;
        wait_out(10);
        checks++; if (got_q.size() !== 10) begin errors++; $display("FAIL t4_count: got %0d beats expected 10", got_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            beat_t e, g;
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL t4_beat: got %h expected %h", g, e); end
        end
    endtask

    task automatic test_reset_mid_frame();
        exp_q.delete(); got_q.delete();
        m_tready = 1'b1;
        for (int i = 0; i < 5; i++) drive_beat({$urandom, $urandom}, '1, 1'b0, 1'b0, 1'b1);
        s_tvalid = 1'b0;
        checks++; if (o_level !== 5'd5) begin errors++; $display("FAIL t5_spec_level: got %0d expected 5", o_level); end
        i_reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL t5_tvalid: got %b expected 0", m_tvalid); end
        checks++; if (m_tdata !== '0) begin errors++; $display("FAIL t5_tdata: got %h expected 0", m_tdata); end
        checks++; if (o_level !== '0) begin errors++; $display("FAIL t5_level: got %0d expected 0", o_level); end
        checks++; if (o_err_drop_cnt !== '0) begin errors++; $display("FAIL t5_err_cnt: got %0d expected 0", o_err_drop_cnt); end
        checks++; if (o_ovf_drop_cnt !== '0) begin errors++; $display("FAIL t5_ovf_cnt: got %0d expected 0", o_ovf_drop_cnt); end
        i_reset = 1'b0;
        got_q.delete();
        send_frame(4, 1'b0, 1'b1, 1'b1);
        wait_out(4);
        checks++; if (got_q.size() !== 4) begin errors++; $display("FAIL t5_count: got %0d beats expected 4", got_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            beat_t e, g;
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL t5_beat: got %h expected %h", g, e); end
        end
        checks++; if (o_level !== '0) begin errors++; $display("FAIL t5_level_end: got %0d expected 0", o_level); end
    endtask

    task automatic test_sat_and_clk_en();
        exp_q.delete(); got_q.delete();
        m_tready = 1'b1;
        for (int f = 0; f < 5; f++) begin
            int want;
            send_frame(2, 1'b1, 1'b0, 1'b1);
            idle(1);
            want = (f + 1 > 3) ? 3 : f + 1;
            checks++;
            if (o_err_drop_cnt !== 2'(want)) begin
                errors++; $display("FAIL t6_err_sat: got %0d expected %0d", o_err_drop_cnt, want);
            end
        end
        vld_seen = 1'b0;
        send_frame(3, 1'b0, 1'b0, 1'b0);
        idle(5);
        checks++; if (o_level !== '0) begin errors++; $display("FAIL t6_clk_en_level: got %0d expected 0", o_level); end
        checks++; if (vld_seen !== 1'b0) begin errors++; $display("FAIL t6_clk_en_output: got tvalid seen=%b expected 0", vld_seen); end
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL t6_clk_en_beats: got %0d expected 0", got_q.size()); end
    endtask

    initial begin
        i_reset = 1'b1; i_clk_en = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
        s_tkeep = '0; s_tdata = '0; m_tready = 1'b0; vld_seen = 1'b0;
        test_reset();
        test_good_frame();
        test_err_frame();
        test_overflow();
        test_back_to_back();
        test_reset_mid_frame();
        test_sat_and_clk_en();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within the time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
